chain_trace_ctrl: RTL
=====================

CHAIN_TRACE_CTRL -- requirements
Module: chain_trace_ctrl

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 4096, meaning the maximum number of move codes accepted per contour.
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock, rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle pulse that begins a trace.
REQ-005 SHALL have ports start_pixel_x and start_pixel_y, input, 6 bits each: contour start coordinate, sampled on start.
REQ-006 SHALL have ports code_valid (input, 1 bit) and code (input, 4 bits): chain code from the serial receiver.
REQ-007 SHALL have port code_ready, output, 1 bit: controller can accept a code.
REQ-008 SHALL have ports mem_we (output, 1 bit), mem_x and mem_y (output, 6 bits each): pixel-map write strobe and address, data implicitly 1.
REQ-009 SHALL have ports current_x and current_y, output, 6 bits each: present trace position.
REQ-010 SHALL have port step_count, output, 16 bits: move codes applied (perimeter).
REQ-011 SHALL have ports busy, done and error, output, 1 bit each.

Function
REQ-012 SHALL implement states IDLE, LOAD, WAIT_CODE, MOVE, WRITE, DONE, ERR.
REQ-013 IDLE: start=1 -> LOAD; latch start coordinate into current_x/y; clear step_count, done, error.
REQ-014 LOAD: assert mem_we for one cycle at the start coordinate -> WAIT_CODE.
REQ-015 WAIT_CODE: code_ready=1; a transfer occurs only when code_valid & code_ready on the same edge; code_ready SHALL be 0 in every other state.
REQ-016 Move encoding (x right, y down): 0 E x+1; 1 NE x+1,y-1; 2 N y-1; 3 NW x-1,y-1; 4 W x-1; 5 SW x-1,y+1; 6 S y+1; 7 SE x+1,y+1.
REQ-017 Code 8 SHALL move WAIT_CODE -> DONE; codes 9-15 SHALL move to ERR.
REQ-018 Codes 0-7 -> MOVE; MOVE computes next coordinate in 7-bit signed arithmetic; any result <0 or >63 -> ERR with current_x/y unchanged.
REQ-019 If step_count == MAX_STEPS when a move code is accepted -> ERR.
REQ-020 Otherwise MOVE -> WRITE, updating current_x/y and incrementing step_count.
REQ-021 WRITE: mem_we=1 for exactly one cycle with mem_x/y = new current_x/y -> WAIT_CODE; accept-to-write latency is 2 cycles.
REQ-022 busy SHALL be 1 in LOAD, WAIT_CODE, MOVE, WRITE; 0 otherwise.
REQ-023 done (DONE) and error (ERR) SHALL be held until the next start; start in DONE or ERR behaves as in IDLE.
REQ-024 start while busy SHALL be ignored.
REQ-025 mem_we SHALL be 0 outside LOAD and WRITE; no write occurs for a rejected move.

Reset
REQ-026 reset SHALL asynchronously force IDLE, including mid-trace.
REQ-027 On reset all outputs SHALL be 0: code_ready, mem_we, mem_x, mem_y, current_x, current_y, step_count, busy, done, error.

Configuration
REQ-028 Macro CLOSURE_CHECK_EN SHALL control contour closure checking.
REQ-029 With CLOSURE_CHECK_EN defined, code 8 SHALL go to DONE only if current_x/y equal the latched start coordinate and step_count>0, else to ERR.
REQ-030 Without CLOSURE_CHECK_EN, code 8 SHALL always go to DONE.

Verification
REQ-031 start (10,10), codes 0,6,4,2,8 -> writes (10,10),(11,10),(11,11),(10,11),(10,10); done=1, step_count=4.
REQ-032 start (0,5), code 4 -> ERR, error=1, no mem_we after LOAD, current_x=0.
REQ-033 code 11 in WAIT_CODE -> ERR next cycle; then start (3,3) -> clears error, LOAD write at (3,3).
REQ-034 Assert reset during WRITE -> all outputs 0 immediately; state IDLE; later start traces normally.
REQ-035 With CLOSURE_CHECK_EN: start (20,20), codes 0,8 -> error=1; without it -> done=1.
REQ-036 code_valid held high with codes 0,0,0 -> exactly one acceptance per 3 cycles; mem_we pulses at (x+1),(x+2),(x+3).

Source files
------------

// File: rtl/chain_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chain_trace_ctrl
// Description : Chain-code contour tracer. On a start pulse it latches a start
//               pixel, writes it to a 64x64 pixel map, then consumes 4-bit
//               chain codes through a valid/ready handshake. Each move code
//               (0-7) steps the trace position by one pixel and writes the new
//               position. Code 8 ends the contour; codes 9-15, moves that
//               leave the 0..63 grid, and moves beyond MAX_STEPS end in error.
//
// Ports       : CLK            - system clock, rising edge
//               reset          - asynchronous active-high reset
//               start          - single-cycle pulse, begins a trace
//               start_pixel_x/y- contour start coordinate (6 bits each)
//               code_valid     - chain code valid from the serial receiver
//               code           - 4-bit chain code
//               code_ready     - controller can accept a code
//               mem_we         - pixel-map write strobe (data implicitly 1)
//               mem_x/mem_y    - pixel-map write address
//               current_x/y    - present trace position
//               step_count     - number of move codes applied (perimeter)
//               busy/done/error- trace status
//
// Build option: define CLOSURE_CHECK_EN to require that the terminating code
//               8 arrives at the start coordinate after at least one move;
//               otherwise the trace ends in error.
//
// Revision    : 1.0 - initial release
// ============================================================================
module chain_trace_ctrl #(
    parameter int MAX_STEPS = 4096
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] start_pixel_x,
    input  logic [5:0] start_pixel_y,
    input  logic       code_valid,
    input  logic [3:0] code,
    output logic       code_ready,
    output logic       mem_we,
    output logic [5:0] mem_x,
    output logic [5:0] mem_y,
    output logic [5:0] current_x,
    output logic [5:0] current_y,
    output logic [15:0] step_count,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [15:0] c_MAX_STEPS = 16'(MAX_STEPS);
    localparam logic [3:0]  c_CODE_END  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_CODE = 3'd2,
        S_MOVE      = 3'd3,
        S_WRITE     = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    state_t            r_state;
    logic [2:0]        r_code;      // accepted move direction, used in MOVE

`ifdef CLOSURE_CHECK_EN
    logic [5:0]        r_start_x;
    logic [5:0]        r_start_y;
    logic              w_closed;
`endif

    logic signed [6:0] w_dx;
    logic signed [6:0] w_dy;
    logic signed [6:0] w_nx;
    logic signed [6:0] w_ny;
    logic              w_out_of_grid;
    logic              w_end_ok;

    // Direction decode: x grows to the right, y grows downward.
    always_comb begin
        w_dx = 7'sd0;
        w_dy = 7'sd0;
        case (r_code)
            3'd0: begin w_dx =  7'sd1; w_dy =  7'sd0; end
            3'd1: begin w_dx =  7'sd1; w_dy = -7'sd1; end
            3'd2: begin w_dx =  7'sd0; w_dy = -7'sd1; end
            3'd3: begin w_dx = -7'sd1; w_dy = -7'sd1; end
            3'd4: begin w_dx = -7'sd1; w_dy =  7'sd0; end
            3'd5: begin w_dx = -7'sd1; w_dy =  7'sd1; end
            3'd6: begin w_dx =  7'sd0; w_dy =  7'sd1; end
            default: begin w_dx = 7'sd1; w_dy = 7'sd1; end
        endcase
    end

    // A position of 0..63 plus or minus one lands in -1..64. In 7-bit signed
    // arithmetic both -1 and 64 have bit 6 set, and no legal result does.
    assign w_nx          = $signed({1'b0, current_x}) + w_dx;
    assign w_ny          = $signed({1'b0, current_y}) + w_dy;
    assign w_out_of_grid = w_nx[6] | w_ny[6];

`ifdef CLOSURE_CHECK_EN
    assign w_closed = (current_x == r_start_x) && (current_y == r_start_y) &&
                      (step_count != 16'd0);
    assign w_end_ok = w_closed;
`else
    assign w_end_ok = 1'b1;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_code     <= 3'd0;
            code_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_x      <= 6'd0;
            mem_y      <= 6'd0;
            current_x  <= 6'd0;
            current_y  <= 6'd0;
            step_count <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef CLOSURE_CHECK_EN
            r_start_x  <= 6'd0;
            r_start_y  <= 6'd0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            mem_we <= 1'b0;

            case (r_state)
                // DONE and ERR hold their flag until the next start, and
                // then restart exactly as IDLE does.
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        current_x  <= start_pixel_x;
                        current_y  <= start_pixel_y;
`ifdef CLOSURE_CHECK_EN
                        r_start_x  <= start_pixel_x;
                        r_start_y  <= start_pixel_y;
`endif
                        step_count <= 16'd0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_x      <= start_pixel_x;
                        mem_y      <= start_pixel_y;
                        r_state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    code_ready <= 1'b1;
                    r_state    <= S_WAIT_CODE;
                end

                S_WAIT_CODE: begin
                    // code_ready is known high in this state, so valid alone
                    // marks a transfer.
                    if (code_valid) begin
                        code_ready <= 1'b0;
                        if (code == c_CODE_END) begin
                            busy <= 1'b0;
                            if (w_end_ok) begin
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                error   <= 1'b1;
                                r_state <= S_ERR;
                            end
                        end else if (code > c_CODE_END) begin
                            busy    <= 1'b0;
                            error   <= 1'b1;
                            r_state <= S_ERR;
                        end else if (step_count == c_MAX_STEPS) begin
                            busy    <= 1'b0;
                            error   <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_code  <= code[2:0];
                            r_state <= S_MOVE;
                        end
                    end
                end

                S_MOVE: begin
                    if (w_out_of_grid) begin
                        // Position stays where it was and nothing is written.
                        busy    <= 1'b0;
                        error   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        current_x  <= w_nx[5:0];
                        current_y  <= w_ny[5:0];
                        step_count <= step_count + 16'd1;
                        mem_we     <= 1'b1;
                        mem_x      <= w_nx[5:0];
                        mem_y      <= w_ny[5:0];
                        r_state    <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    code_ready <= 1'b1;
                    r_state    <= S_WAIT_CODE;
                end

                default: begin
                    code_ready <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
